// File: rtl/sata_port_regs.sv
// Host register block for one SATA port: synchronised link/PLL status with sticky
// change interrupts, a DMA descriptor queue, StartComm pulse timer and FIS read window.
module sata_port_regs #(
    parameter int C_DMA_DEPTH   = 4,
    parameter int C_SYNC_STAGES = 2,
    parameter int C_COM_PULSE   = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [5:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        linkup,
    input  logic        plllock,
    input  logic        rxfifo_irq,
    input  logic        cxfifo_irq,
    input  logic [3:0]  error_code,
    input  logic [11:0] rxfifo_fis_hdr,
    output logic        cxfifo_ack,
    output logic        cxfifo_ok,
    output logic        StartComm,
    output logic        phyreset,
    output logic        dma_req,
    output logic [31:0] dma_address,
    output logic [15:0] dma_length,
    output logic [7:0]  dma_flags,
    input  logic        dma_ack,
    output logic [2:0]  rxfis_raddr,
    input  logic [31:0] rxfis_rdata
);

    localparam int PTR_W = $clog2(C_DMA_DEPTH);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(C_DMA_DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   LVL_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [7:0]       COM_LOAD = 8'(C_COM_PULSE);

    logic [C_SYNC_STAGES-1:0] linkup_sync_r;
    logic [C_SYNC_STAGES-1:0] plllock_sync_r;
    logic        linkup_prev_r;
    logic        plllock_prev_r;
    logic        link_chg_r;
    logic        pll_chg_r;
    logic        dma_done_r;
    logic        dma_ovf_r;
    logic [5:0]  irq_en_r;
    logic        irq_r;
    logic        phyreset_r;
    logic [31:0] dma_stage_r;
    logic [31:0] fifo_addr_r  [C_DMA_DEPTH];
    logic [15:0] fifo_len_r   [C_DMA_DEPTH];
    logic [7:0]  fifo_flags_r [C_DMA_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic [7:0]  done_cnt_r;
    logic [7:0]  com_cnt_r;
    logic        cxfifo_ack_r;
    logic        cxfifo_ok_r;
    logic [31:0] readdata_r;

    logic [3:0]  widx_s;
    logic [15:0] wr_sel_s;
    logic        linkup_sync_s;
    logic        plllock_sync_s;
    logic [5:0]  w1c_s;
    logic [5:0]  irq_stat_s;
    logic        dma_empty_s;
    logic        dma_full_s;
    logic        pop_s;
    logic        push_req_s;
    logic        push_s;
    logic        ovf_set_s;
    logic        flush_s;
    logic        start_comm_s;
    logic [7:0]  level8_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign widx_s         = address[5:2];
    assign wr_sel_s       = {15'b0, write} << widx_s;
    assign linkup_sync_s  = linkup_sync_r[C_SYNC_STAGES-1];
    assign plllock_sync_s = plllock_sync_r[C_SYNC_STAGES-1];
    assign w1c_s          = wr_sel_s[2] ? writedata[5:0] : 6'b0;
    assign irq_stat_s     = {dma_ovf_r, dma_done_r, cxfifo_irq, rxfifo_irq, pll_chg_r, link_chg_r};

    // A push at full is still accepted when the head leaves in the same cycle.
    assign dma_empty_s  = (level_r == LVL_ZERO);
    assign dma_full_s   = (level_r == FULL_LVL);
    assign pop_s        = dma_ack & ~dma_empty_s;
    assign push_req_s   = wr_sel_s[5];
    assign push_s       = push_req_s & (~dma_full_s | pop_s);
    assign ovf_set_s    = push_req_s & dma_full_s & ~pop_s;
    assign flush_s      = wr_sel_s[1] & writedata[0];
    assign start_comm_s = wr_sel_s[0] & writedata[28];

    generate
        if (PTR_W + 1 >= 8) begin : g_lvl_trunc
            assign level8_s = level_r[7:0];
        end else begin : g_lvl_ext
            assign level8_s = {{(7 - PTR_W){1'b0}}, level_r};
        end
    endgenerate

    assign readdata    = readdata_r;
    assign irq         = irq_r;
    assign cxfifo_ack  = cxfifo_ack_r;
    assign cxfifo_ok   = cxfifo_ok_r;
    assign StartComm   = (com_cnt_r != 8'd0);
    assign phyreset    = phyreset_r;
    assign dma_req     = ~dma_empty_s;
    assign dma_address = dma_empty_s ? 32'h0 : fifo_addr_r[rd_ptr_r];
    assign dma_length  = dma_empty_s ? 16'h0 : fifo_len_r[rd_ptr_r];
    assign dma_flags   = dma_empty_s ? 8'h0  : fifo_flags_r[rd_ptr_r];
    assign rxfis_raddr = address[4:2];
    assign unused_s    = ^address[1:0];

    // Status line synchronisers and previous-value flops for change detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            linkup_sync_r  <= {C_SYNC_STAGES{1'b0}};
            plllock_sync_r <= {C_SYNC_STAGES{1'b0}};
            linkup_prev_r  <= 1'b0;
            plllock_prev_r <= 1'b0;
        end else begin
            linkup_sync_r  <= {linkup_sync_r[C_SYNC_STAGES-2:0], linkup};
            plllock_sync_r <= {plllock_sync_r[C_SYNC_STAGES-2:0], plllock};
            linkup_prev_r  <= linkup_sync_s;
            plllock_prev_r <= plllock_sync_s;
        end
    end

    // Sticky interrupt bits: clear first, then set so a same-cycle event survives
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            link_chg_r <= 1'b0;
            pll_chg_r  <= 1'b0;
            dma_done_r <= 1'b0;
            dma_ovf_r  <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            link_chg_r <= (link_chg_r & ~w1c_s[0]) | (linkup_sync_s ^ linkup_prev_r);
            pll_chg_r  <= (pll_chg_r & ~w1c_s[1]) | (plllock_sync_s ^ plllock_prev_r);
            dma_done_r <= (dma_done_r & ~w1c_s[4]) | pop_s;
            dma_ovf_r  <= (dma_ovf_r & ~w1c_s[5]) | ovf_set_s;
            irq_r      <= |(irq_stat_s & irq_en_r);
        end
    end

    // Plain read/write control registers and command pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq_en_r     <= 6'h0;
            phyreset_r   <= 1'b1;
            dma_stage_r  <= 32'h0;
            cxfifo_ack_r <= 1'b0;
            cxfifo_ok_r  <= 1'b0;
        end else begin
            if (wr_sel_s[3]) begin
                irq_en_r <= writedata[5:0];
            end
            if (wr_sel_s[1]) begin
                phyreset_r <= writedata[31];
            end
            if (wr_sel_s[4]) begin
                dma_stage_r <= writedata;
            end
            cxfifo_ack_r <= wr_sel_s[0] & writedata[31];
            cxfifo_ok_r  <= wr_sel_s[0] & writedata[30];
        end
    end

    // Descriptor storage; contents are only observed through a valid head pointer
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r]  <= dma_stage_r;
            fifo_len_r[wr_ptr_r]   <= writedata[15:0];
            fifo_flags_r[wr_ptr_r] <= writedata[23:16];
        end
    end

    // Queue pointers, fill level and completed-descriptor counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            done_cnt_r <= 8'd0;
        end else begin
            if (pop_s) begin
                done_cnt_r <= done_cnt_r + 8'd1;
            end
            if (flush_s) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
                level_r  <= LVL_ZERO;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   level_r <= level_r + LVL_ONE;
                    2'b01:   level_r <= level_r - LVL_ONE;
                    default: level_r <= level_r;
                endcase
            end
        end
    end

    // StartComm timer; a new request reloads and so stretches the pulse
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            com_cnt_r <= 8'd0;
        end else if (start_comm_s) begin
            com_cnt_r <= COM_LOAD;
        end else if (com_cnt_r != 8'd0) begin
            com_cnt_r <= com_cnt_r - 8'd1;
        end
    end

    // Read multiplexer; the upper half of the map is the received-FIS window
    always_comb begin
        rd_mux_s = 32'h0;
        if (address[5]) begin
            rd_mux_s = rxfis_rdata;
        end else begin
            case (widx_s[2:0])
                3'd0:    rd_mux_s = {cxfifo_irq, rxfifo_irq, plllock_sync_s, linkup_sync_s,
                                     12'h0, error_code, rxfifo_fis_hdr};
                3'd1:    rd_mux_s = {phyreset_r, 31'h0};
                3'd2:    rd_mux_s = {26'h0, irq_stat_s};
                3'd3:    rd_mux_s = {26'h0, irq_en_r};
                3'd4:    rd_mux_s = dma_stage_r;
                3'd5:    rd_mux_s = {8'h0, dma_flags, dma_length};
                3'd6:    rd_mux_s = {14'h0, dma_full_s, dma_empty_s, level8_s, done_cnt_r};
                default: rd_mux_s = 32'h0;
            endcase
        end
    end

    // Registered read data
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            readdata_r <= 32'h0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_sata_port_regs.sv
// Randomised bench for sata_port_regs, checked against a queue-based register model.
module tb_sata_port_regs;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int PULSE = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [5:0]  address = 6'h0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        irq;
    logic        linkup = 1'b0;
    logic        plllock = 1'b0;
    logic        rxfifo_irq = 1'b0;
    logic        cxfifo_irq = 1'b0;
    logic [3:0]  error_code = 4'h0;
    logic [11:0] rxfifo_fis_hdr = 12'h0;
    logic        cxfifo_ack;
    logic        cxfifo_ok;
    logic        StartComm;
    logic        phyreset;
    logic        dma_req;
    logic [31:0] dma_address;
    logic [15:0] dma_length;
    logic [7:0]  dma_flags;
    logic        dma_ack = 1'b0;
    logic [2:0]  rxfis_raddr;
    logic [31:0] rxfis_rdata = 32'h0;

    sata_port_regs #(
        .C_DMA_DEPTH  (DEPTH),
        .C_SYNC_STAGES(SYNC),
        .C_COM_PULSE  (PULSE)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .irq           (irq),
        .linkup        (linkup),
        .plllock       (plllock),
        .rxfifo_irq    (rxfifo_irq),
        .cxfifo_irq    (cxfifo_irq),
        .error_code    (error_code),
        .rxfifo_fis_hdr(rxfifo_fis_hdr),
        .cxfifo_ack    (cxfifo_ack),
        .cxfifo_ok     (cxfifo_ok),
        .StartComm     (StartComm),
        .phyreset      (phyreset),
        .dma_req       (dma_req),
        .dma_address   (dma_address),
        .dma_length    (dma_length),
        .dma_flags     (dma_flags),
        .dma_ack       (dma_ack),
        .rxfis_raddr   (rxfis_raddr),
        .rxfis_rdata   (rxfis_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] l;
        logic [7:0]  f;
    } desc_t;

    desc_t       q[$];
    logic [7:0]  m_done_cnt;
    logic        m_ovf, m_done, m_link_chg, m_pll_chg, m_phy;
    logic [5:0]  m_en;
    logic [31:0] m_stage;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic reset_model();
        q.delete();
        m_done_cnt = 8'h0;
        m_ovf      = 1'b0;
        m_done     = 1'b0;
        m_link_chg = 1'b0;
        m_pll_chg  = 1'b0;
        m_phy      = 1'b1;
        m_en       = 6'h0;
        m_stage    = 32'h0;
    endtask

    function automatic logic [5:0] m_stat();
        return {m_ovf, m_done, cxfifo_irq, rxfifo_irq, m_pll_chg, m_link_chg};
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a >= 6'h20) begin
            v = rxfis_rdata;
        end else begin
            case (a[4:2])
                3'd0: v = {cxfifo_irq, rxfifo_irq, plllock, linkup, 12'h0, error_code, rxfifo_fis_hdr};
                3'd1: v = {m_phy, 31'h0};
                3'd2: v = {26'h0, m_stat()};
                3'd3: v = {26'h0, m_en};
                3'd4: v = m_stage;
                3'd5: if (q.size() > 0) v = {8'h0, q[0].f, q[0].l};
                3'd6: v = {14'h0, q.size() == DEPTH, q.size() == 0, 8'(q.size()), m_done_cnt};
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    // One bus cycle: drive, clock, update the model, compare outputs.
    task automatic cycle(input logic [5:0] a, input logic wr, input logic [31:0] wd,
                         input logic ack, input logic chk_rd);
        logic        exp_irq;
        logic [31:0] exp_rd;
        logic        pop;
        address   = a;
        write     = wr;
        writedata = wd;
        dma_ack   = ack;
        exp_irq   = |(m_stat() & m_en);
        exp_rd    = m_read(a);
        tick();
        write   = 1'b0;
        dma_ack = 1'b0;
        pop = ack && (q.size() > 0);
        if (wr && a[5:2] == 4'h2) begin
            if (wd[0]) m_link_chg = 1'b0;
            if (wd[1]) m_pll_chg = 1'b0;
            if (wd[4]) m_done = 1'b0;
            if (wd[5]) m_ovf = 1'b0;
        end
        if (wr && a[5:2] == 4'h3) m_en = wd[5:0];
        if (wr && a[5:2] == 4'h4) m_stage = wd;
        if (wr && a[5:2] == 4'h1) begin
            m_phy = wd[31];
            if (wd[0]) q.delete();
        end
        if (pop) begin
            void'(q.pop_front());
            m_done = 1'b1;
            m_done_cnt++;
        end
        if (wr && a[5:2] == 4'h5) begin
            if (q.size() < DEPTH) q.push_back('{m_stage, wd[15:0], wd[23:16]});
            else m_ovf = 1'b1;
        end
        chk("irq", 32'(irq), 32'(exp_irq));
        chk("dma_req", 32'(dma_req), 32'(q.size() > 0));
        chk("phyreset", 32'(phyreset), 32'(m_phy));
        if (q.size() > 0) begin
            chk("head_addr", dma_address, q[0].a);
            chk("head_len", 32'(dma_length), 32'(q[0].l));
            chk("head_flags", 32'(dma_flags), 32'(q[0].f));
        end
        if (chk_rd) chk($sformatf("read_%02h", a), readdata, exp_rd);
    endtask

    initial begin
        logic [31:0] first_addr;
        logic [31:0] ad;
        logic [5:0]  ra;
        int          op;

        reset_model();
        sys_rst = 1'b1;
        tick();
        tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_startcomm", 32'(StartComm), 32'h0);
        chk("rst_phyreset", 32'(phyreset), 32'h1);
        chk("rst_dma_req", 32'(dma_req), 32'h0);
        chk("rst_dma_fields", {dma_address[15:0] | dma_length, dma_flags, 6'h0, cxfifo_ack, cxfifo_ok}, 32'h0);
        chk("rst_dma_addr", dma_address, 32'h0);
        sys_rst = 1'b0;

        cycle(6'h04, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("ctrl_reset_value", readdata, 32'h8000_0000);
        cycle(6'h0C, 1'b0, 32'h0, 1'b0, 1'b1);

        // linkup edge latency, W1C, and set-wins-over-clear
        cycle(6'h0C, 1'b1, 32'h1, 1'b0, 1'b0);
        address = 6'h08;
        linkup  = 1'b1;
        repeat (SYNC + 1) tick();
        chk("link_early_irq", 32'(irq), 32'h0);
        chk("link_early_stat", readdata, 32'h0);
        tick();
        chk("link_irq", 32'(irq), 32'h1);
        chk("link_stat", readdata, 32'h1);
        m_link_chg = 1'b1;
        cycle(6'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(6'h08, 1'b1, 32'h1, 1'b0, 1'b0);
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        linkup = 1'b0;
        repeat (SYNC) tick();
        cycle(6'h08, 1'b1, 32'h1, 1'b0, 1'b0);
        m_link_chg = 1'b1;
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(6'h08, 1'b1, 32'h1, 1'b0, 1'b0);
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        plllock = 1'b1;
        repeat (SYNC + 2) tick();
        m_pll_chg = 1'b1;
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        plllock = 1'b0;
        repeat (SYNC + 2) tick();
        cycle(6'h08, 1'b1, 32'h2, 1'b0, 1'b0);
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);

        // fill past full, then drain including a push+ack at full
        first_addr = 32'h0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            ad = $urandom;
            if (i == 0) first_addr = ad;
            cycle(6'h10, 1'b1, ad, 1'b0, 1'b0);
            cycle(6'h14, 1'b1, $urandom, 1'b0, 1'b0);
        end
        chk("dma_head_first", dma_address, first_addr);
        cycle(6'h18, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("dma_level_full", 32'(readdata[17:8]), 32'h204);
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("dma_ovf_bit", 32'(readdata[5]), 32'h1);
        cycle(6'h14, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(6'h10, 1'b1, $urandom, 1'b0, 1'b0);
        cycle(6'h14, 1'b1, $urandom, 1'b0, 1'b0);
        cycle(6'h10, 1'b1, $urandom, 1'b0, 1'b0);
        cycle(6'h14, 1'b1, $urandom, 1'b1, 1'b0);
        cycle(6'h18, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) cycle(6'h18, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(6'h18, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(6'h18, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("done_cnt_after_drain", readdata, 32'h0001_0006);

        // StartComm width and extension
        cycle(6'h00, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        for (int k = 0; k < PULSE + 2; k++) begin
            chk($sformatf("startcomm_%0d", k), 32'(StartComm), 32'(k < PULSE));
            cycle(6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        cycle(6'h00, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        for (int k = 0; k < PULSE + 4; k++) begin
            chk($sformatf("startcomm_ext_%0d", k), 32'(StartComm), 32'(k < PULSE + 2));
            cycle(6'h00, (k == 1), 32'h1000_0000, 1'b0, 1'b0);
        end

        // command pulses
        cycle(6'h00, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        chk("cx_ack_pulse", {30'h0, cxfifo_ack, cxfifo_ok}, 32'h2);
        cycle(6'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("cx_ack_end", {30'h0, cxfifo_ack, cxfifo_ok}, 32'h0);
        cycle(6'h00, 1'b1, 32'h4000_0000, 1'b0, 1'b0);
        chk("cx_ok_pulse", {30'h0, cxfifo_ack, cxfifo_ok}, 32'h1);

        // FIS window and unmapped hole
        rxfis_rdata = $urandom;
        address = 6'h24;
        #1;
        chk("fis_raddr", 32'(rxfis_raddr), 32'h1);
        cycle(6'h24, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(6'h1C, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("unmapped_1c", readdata, 32'h0);

        // randomised traffic against the model
        for (int it = 0; it < 1200; it++) begin
            rxfifo_irq     = 1'($urandom_range(0, 1));
            cxfifo_irq     = 1'($urandom_range(0, 1));
            error_code     = 4'($urandom);
            rxfifo_fis_hdr = 12'($urandom);
            rxfis_rdata    = $urandom;
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    cycle(6'h10, 1'b1, $urandom, 1'b0, 1'b0);
                    cycle(6'h14, 1'b1, $urandom, ($urandom_range(0, 2) == 0), 1'b0);
                end
                2, 3: cycle(6'h18, 1'b0, 32'h0, 1'b1, 1'b0);
                4: cycle(6'h04, 1'b1, $urandom & 32'h8000_0001, 1'b0, 1'b0);
                5: cycle(6'h08, 1'b1, $urandom & 32'h3F, 1'b0, 1'b0);
                6: cycle(6'h0C, 1'b1, $urandom & 32'h3F, 1'b0, 1'b0);
                default: begin
                    ra = {4'($urandom), 2'b00};
                    if (ra == 6'h14 && q.size() == 0) ra = 6'h18;
                    cycle(ra, 1'b0, 32'h0, 1'b0, 1'b1);
                end
            endcase
        end

        // reset in the middle of activity
        cycle(6'h10, 1'b1, $urandom, 1'b0, 1'b0);
        cycle(6'h14, 1'b1, $urandom, 1'b0, 1'b0);
        cycle(6'h0C, 1'b1, 32'h3F, 1'b0, 1'b0);
        cycle(6'h00, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        sys_rst = 1'b1;
        tick();
        chk("midrst_startcomm", 32'(StartComm), 32'h0);
        chk("midrst_dma_req", 32'(dma_req), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_phyreset", 32'(phyreset), 32'h1);
        chk("midrst_readdata", readdata, 32'h0);
        sys_rst = 1'b0;
        reset_model();
        cycle(6'h18, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("midrst_dma_stat", readdata, 32'h0001_0000);
        cycle(6'h08, 1'b0, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sata_port_regs.md
# sata_port_regs

Parametrised register and control interface for one SATA port, sitting between the host register bus and the link/DMA engines. It synchronises and edge-detects the link and PLL status lines, and keeps sticky write-1-to-clear interrupt status with an enable mask. It queues DMA descriptors in a configurable-depth FIFO with a req/ack handshake, and it generates a sized StartComm pulse. The received-FIS window is exposed through the same read path.

## Interface
- C_DMA_DEPTH, 4: descriptor FIFO depth; must be a power of 2, at least 2.
- C_SYNC_STAGES, 2: synchroniser flops on `linkup` and `plllock`; at least 2.
- C_COM_PULSE, 4: StartComm pulse width in cycles; range 1..255.
- sys_clk  in  1  the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- address  in  6  byte address; bits [1:0] are ignored.
- write  in  1  write strobe, one cycle.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  registered interrupt = OR of (IRQ_STAT & IRQ_EN).
- linkup, plllock  in  1 each  asynchronous status levels.
- rxfifo_irq, cxfifo_irq  in  1 each  level requests, already in the sys_clk domain.
- error_code  in  4, rxfifo_fis_hdr  in  12  status fields.
- cxfifo_ack, cxfifo_ok  out  1 each  one-cycle command pulses.
- StartComm  out  1  COMRESET request pulse.
- phyreset  out  1  PHY reset level.
- dma_req  out  1  high while the queue is non-empty.
- dma_address  out  32, dma_length  out  16, dma_flags  out  8  head descriptor fields.
- dma_ack  in  1  one-cycle pulse; consumes the head descriptor.
- rxfis_raddr  out  3  FIS word index = address[4:2]; combinational.
- rxfis_rdata  in  32  FIS word, valid in the same cycle as rxfis_raddr.

## Operation
- Register map:
  - 0x00 STATUS read: [11:0] fis_hdr, [15:12] error_code, [28] linkup_sync, [29] plllock_sync, [30] rxfifo_irq, [31] cxfifo_irq.
  - 0x00 COMMAND write: [31] pulse cxfifo_ack, [30] pulse cxfifo_ok, [28] start comm.
  - 0x04 CTRL: [31] phyreset, read/write, reset value 1. [0] flush queue, write-1, self-clearing, reads 0.
  - 0x08 IRQ_STAT, write-1-to-clear: [0] linkup changed, [1] plllock changed, [2] rxfifo_irq (read-only mirror), [3] cxfifo_irq (read-only mirror), [4] DMA done, [5] queue overflow.
  - 0x0C IRQ_EN, read/write [5:0], reset value 0.
  - 0x10 DMA_ADDR staging register, read/write.
  - 0x14 DMA_CMD: a write pushes {DMA_ADDR, writedata[15:0] length, writedata[23:16] flags}. A read returns the head descriptor's length and flags.
  - 0x18 DMA_STAT, read-only: [7:0] done_cnt, [15:8] level, [16] empty, [17] full.
  - 0x20–0x3C: FIS window; readdata is loaded from rxfis_rdata.
  - Unmapped addresses read 0.
- Status edges: each synchronised level is compared with its previous value; any change sets the sticky bit.
- Set and W1C in the same cycle: set wins.
- DMA queue behaviour:
  - Push when full and no pop in that cycle: the descriptor is dropped and overflow is set.
  - Push and pop in the same cycle at full: both are accepted; the level is unchanged.
  - dma_ack while empty: ignored; done is not set.
  - Each accepted ack sets done and increments done_cnt; done_cnt is 8-bit and wraps 255 -> 0.
  - Flush empties the queue. done_cnt is not changed.
- StartComm: a start-comm write loads the counter with C_COM_PULSE. StartComm = (counter != 0). A new start-comm write during a pulse reloads the counter, extending the pulse.
- Reset mid-operation: the queue is emptied, counters and sticky bits are cleared, and all pulses stop in the next cycle.

## Timing
- Reset values: readdata 0, irq 0, StartComm 0, phyreset 1, dma_req 0, dma_address/length/flags 0, cxfifo_ack/ok 0. rxfis_raddr follows address.
- Read latency: 1 cycle. readdata is registered from the address presented in cycle N and is valid in N+1.
- Write effect: a register written in cycle N reads back its new value in N+1. cxfifo_ack/ok pulse in N+1.
- StartComm: asserts in N+1 and stays high for exactly C_COM_PULSE cycles.
- Push: if the push is at cycle N into an empty queue, dma_req and the head fields are valid in N+1.
- Pop: if dma_ack is at cycle N, the next head, or dma_req=0, appears in N+1. Head fields must be stable while dma_req=1 and no ack arrives.
- irq: updates 1 cycle after the IRQ_STAT or IRQ_EN change.
- linkup/plllock edge -> sticky bit set: C_SYNC_STAGES+1 cycles.

## Test plan
- Reset. Read 0x04 -> 0x80000000. Read 0x0C -> 0. Check irq=0 and dma_req=0.
- Toggle linkup 0->1 with IRQ_EN=0x01:
  - bit0 of 0x08 sets and irq=1.
  - Write 0x08=0x01 -> bit clears and irq=0 one cycle later.
  - Edge on the same cycle as the W1C -> bit stays 1.
- With C_DMA_DEPTH=4, push 5 descriptors without ack:
  - DMA_STAT level=4 and full=1.
  - IRQ_STAT bit5 set.
  - dma_address equals the first pushed address.
- Ack 4 times (including one ack on the same cycle as a push at full):
  - Descriptors come out in FIFO order.
  - done_cnt is incremented by 4.
  - dma_req falls the cycle after the last ack.
  - An extra ack while empty has no effect.
- Write 0x00 bit28 with C_COM_PULSE=4 -> StartComm high for 4 cycles. Re-write at pulse cycle 2 -> high for 6 cycles total.
- Read 0x24 -> rxfis_raddr=1 and readdata=rxfis_rdata one cycle later. Read 0x1C -> 0.
